// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry sequencer: FSM state
// encodings, key codes, operand-memory addresses and key decode helpers.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_A_ENTRY  = 3'b000,
    ST_OP_ENTRY = 3'b001,
    ST_B_ENTRY  = 3'b010,
    ST_EXEC     = 3'b011,
    ST_RESULT   = 3'b100,
    ST_ERROR    = 3'b101,
    ST_CLEARING = 3'b110
  } calc_state_e;

  // Key codes: 1..9 are digits 1..9, 10 is digit 0.
  localparam logic [4:0] KEY_DIGIT0 = 5'd10;
  localparam logic [4:0] KEY_ADD    = 5'd11;
  localparam logic [4:0] KEY_SUB    = 5'd12;
  localparam logic [4:0] KEY_MUL    = 5'd13;
  localparam logic [4:0] KEY_DIV    = 5'd14;
  localparam logic [4:0] KEY_ENTER  = 5'd15;
  localparam logic [4:0] KEY_CLEAR  = 5'd16;

  // Operand-memory layout: A tens, A ones, operator, B tens, B ones.
  localparam logic [2:0] ADR_TENS1 = 3'd0;
  localparam logic [2:0] ADR_ONES1 = 3'd1;
  localparam logic [2:0] ADR_OP    = 3'd2;
  localparam logic [2:0] ADR_TENS2 = 3'd3;
  localparam logic [2:0] ADR_ONES2 = 3'd4;

  localparam int TIMEOUT_DEFAULT = 255;

  function automatic logic is_digit(input logic [4:0] code);
    return (code >= 5'd1) && (code <= KEY_DIGIT0);
  endfunction

  function automatic logic is_operator(input logic [4:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB) ||
           (code == KEY_MUL) || (code == KEY_DIV);
  endfunction

  // Decimal value of a digit key; the "0" key has code 10.
  function automatic logic [4:0] digit_value(input logic [4:0] code);
    return (code == KEY_DIGIT0) ? 5'd0 : code;
  endfunction

endpackage

// File: rtl/calc_timeout_counter.sv
// Counts cycles spent in EXEC and flags the last permitted cycle so the
// FSM can abandon a calculation whose ALU never answers.
module calc_timeout_counter
  import calc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk_manual_verify,
  input  logic reset_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  // Cycle counter: zero outside EXEC, increments each EXEC cycle.
  always_ff @(posedge clk_manual_verify or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    if (!reset_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && !expired_o) begin
      count_q <= count_q + CW'(1);
    end
  end

  // Expired during the TIMEOUT-th EXEC cycle, so EXEC lasts TIMEOUT cycles.
  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/calc_entry_sequencer.sv
// Key-entry sequencer for a two-digit calculator: captures operand A,
// operator and operand B into a five-entry operand memory, launches the
// ALU, waits for its result or a timeout, and sweeps the memory on clear.
module calc_entry_sequencer
  import calc_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk_manual_verify,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       alu_done,
  input  logic       alu_err,
  output logic       wr_en,
  output logic [2:0] wr_adr,
  output logic [4:0] wr_data,
  output logic       alu_start,
  output logic [2:0] state,
  output logic [1:0] digit_cnt,
  output logic       error,
  output logic       busy
);

  calc_state_e state_q, state_d;
  logic [2:0]  sweep_q, sweep_d;
  logic [1:0]  digit_cnt_q, digit_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_adr_q, wr_adr_d;
  logic [4:0]  wr_data_q, wr_data_d;
  logic        alu_start_q, alu_start_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;

  logic        key_clear;
  logic        key_digit;
  logic        timeout_expired;

  assign key_clear = key_valid && (key_code == KEY_CLEAR);
  assign key_digit = key_valid && is_digit(key_code);

  calc_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_manual_verify (clk_manual_verify),
    .reset_n           (reset_n),
    .clear_i           (state_q != ST_EXEC),
    .enable_i          (state_q == ST_EXEC),
    .expired_o         (timeout_expired)
  );

  // Next-state and registered-output logic for the whole entry sequence.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    sweep_d     = sweep_q;
    digit_cnt_d = digit_cnt_q;
    wr_en_d     = 1'b0;
    wr_adr_d    = wr_adr_q;
    wr_data_d   = wr_data_q;
    alu_start_d = 1'b0;

    if (key_clear) begin
      // Clear beats every other event; in CLEARING it restarts the sweep.
      state_d     = ST_CLEARING;
      sweep_d     = ADR_TENS1;
      digit_cnt_d = 2'd0;
    end else begin
      unique case (state_q)
        ST_CLEARING: begin
          wr_en_d   = 1'b1;
          wr_adr_d  = sweep_q;
          wr_data_d = 5'd0;
          if (sweep_q == ADR_ONES2) begin
            state_d     = ST_A_ENTRY;
            digit_cnt_d = 2'd0;
          end else begin
            sweep_d = sweep_q + 3'd1;
          end
        end

        ST_A_ENTRY: begin
          if (key_digit) begin
            wr_en_d   = 1'b1;
            wr_data_d = digit_value(key_code);
            if (digit_cnt_q == 2'd0) begin
              wr_adr_d    = ADR_TENS1;
              digit_cnt_d = 2'd1;
            end else begin
              wr_adr_d    = ADR_ONES1;
              digit_cnt_d = 2'd0;
              state_d     = ST_OP_ENTRY;
            end
          end
        end

        ST_OP_ENTRY: begin
          if (key_valid && is_operator(key_code)) begin
            wr_en_d   = 1'b1;
            wr_adr_d  = ADR_OP;
            wr_data_d = key_code;
            state_d   = ST_B_ENTRY;
          end
        end

        ST_B_ENTRY: begin
          if (key_digit && (digit_cnt_q != 2'd2)) begin
            wr_en_d     = 1'b1;
            wr_adr_d    = (digit_cnt_q == 2'd0) ? ADR_TENS2 : ADR_ONES2;
            wr_data_d   = digit_value(key_code);
            digit_cnt_d = digit_cnt_q + 2'd1;
          end else if (key_valid && (key_code == KEY_ENTER) &&
                       (digit_cnt_q == 2'd2)) begin
            alu_start_d = 1'b1;
            state_d     = ST_EXEC;
          end
        end

        ST_EXEC: begin
          // alu_done is ignored while the launch pulse is still on the wire.
          if (alu_done && !alu_start_q) begin
            state_d = alu_err ? ST_ERROR : ST_RESULT;
          end else if (timeout_expired) begin
            state_d = ST_ERROR;
          end
        end

        ST_RESULT: begin
          if (key_digit) begin
            wr_en_d     = 1'b1;
            wr_adr_d    = ADR_TENS1;
            wr_data_d   = digit_value(key_code);
            digit_cnt_d = 2'd1;
            state_d     = ST_A_ENTRY;
          end
        end

        ST_ERROR: begin
          state_d = ST_ERROR;
        end

        default: begin
          state_d     = ST_CLEARING;
          sweep_d     = ADR_TENS1;
          digit_cnt_d = 2'd0;
        end
      endcase
    end

    error_d = (state_d == ST_ERROR);
    busy_d  = (state_d == ST_CLEARING) || (state_d == ST_EXEC);
  end

  // State and output registers; reset lands in a fresh CLEARING sweep.
  always_ff @(posedge clk_manual_verify or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_CLEARING;
      sweep_q     <= ADR_TENS1;
      digit_cnt_q <= 2'd0;
      wr_en_q     <= 1'b0;
      wr_adr_q    <= 3'd0;
      wr_data_q   <= 5'd0;
      alu_start_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      digit_cnt_q <= digit_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_adr_q    <= wr_adr_d;
      wr_data_q   <= wr_data_d;
      alu_start_q <= alu_start_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign state     = state_q;
  assign digit_cnt = digit_cnt_q;
  assign wr_en     = wr_en_q;
  assign wr_adr    = wr_adr_q;
  assign wr_data   = wr_data_q;
  assign alu_start = alu_start_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule
